// File: rtl/lmem_pkg.sv
// Shared types and constants for the LMEM read-side stream sequencer.
package lmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lmem_rd_state_t;

  // Output buffer depth; together with the one-cycle read latency this
  // bounds how many words can be outstanding under backpressure.
  localparam int LMEM_RD_BUF_DEPTH = 2;
  localparam int LMEM_RD_OCC_W     = $clog2(LMEM_RD_BUF_DEPTH + 1);

endpackage

// File: rtl/lmem_skid_fifo.sv
// Two-entry registered FIFO that absorbs downstream stalls while a read is
// still in flight. The head entry is always a register so the stream data
// and valid never depend combinationally on the consumer.
module lmem_skid_fifo
  import lmem_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [LMEM_RD_OCC_W-1:0] occupancy,
  output logic [DATA_WIDTH-1:0]    head_data
);

  localparam logic [LMEM_RD_OCC_W-1:0] OCC_ONE  = LMEM_RD_OCC_W'(1);
  localparam logic [LMEM_RD_OCC_W-1:0] OCC_FULL = LMEM_RD_OCC_W'(LMEM_RD_BUF_DEPTH);

  logic [DATA_WIDTH-1:0] tail_data;
  logic                  do_pop;
  logic                  do_push;

  // A pop on an empty buffer and a push into a full one without a
  // simultaneous pop are both dropped so the occupancy can never wrap.
  assign do_pop  = pop && (occupancy != '0);
  assign do_push = push && (do_pop || (occupancy != OCC_FULL));

  // Head/tail shift structure: pops move the tail forward into the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occupancy == '0) begin
            head_data <= push_data;
          end else begin
            tail_data <= push_data;
          end
          occupancy <= occupancy + OCC_ONE;
        end
        2'b01: begin
          head_data <= tail_data;
          occupancy <= occupancy - OCC_ONE;
        end
        2'b11: begin
          if (occupancy == OCC_ONE) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/lmem_stream_reader.sv
// Read-side sequencer for an LMEM with one registered read port. Walks a
// contiguous (wrapping) address range, absorbs the one-cycle read latency
// and presents the words as a valid/ready stream through a 2-entry buffer.
module lmem_stream_reader
  import lmem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int RW = ADDR_WIDTH + 1;
  localparam int CW = LMEM_RD_OCC_W + 1;

  lmem_rd_state_t             state;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [RW-1:0]              remaining;
  logic                       inflight;
  logic [LMEM_RD_OCC_W-1:0]   occupancy;
  logic                       pop;
  logic [CW-1:0]              credit;
  logic                       issue;
  logic                       last_issue;
  logic                       drain_done;

  // Free slots counting the word already in flight; a pop this cycle frees
  // one slot in time for the read issued now to land in it.
  assign credit = CW'(LMEM_RD_BUF_DEPTH) + CW'(pop) - CW'(occupancy) - CW'(inflight);

  assign pop        = out_valid && out_ready;
  assign out_valid  = (occupancy != '0);
  assign issue      = (state == RUN) && (credit != '0);
  assign last_issue = issue && (remaining == RW'(1));
  assign raddr      = addr_q;

  // Finish as soon as the buffer will be empty next cycle, so done lands in
  // the cycle right after the final handshake.
  assign drain_done = (state == DRAIN) && !inflight &&
                      ((occupancy - LMEM_RD_OCC_W'(pop)) == '0);

  // Command FSM with address/remaining counters and the in-flight flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              state     <= RUN;
              addr_q    <= base_addr;
              remaining <= len;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            remaining <= remaining - RW'(1);
            if (last_issue) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  lmem_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (rdata),
    .pop       (pop),
    .occupancy (occupancy),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_lmem_stream_reader.sv
// Directed bench for lmem_stream_reader with a registered-read LMEM model
// preloaded with mem[i] = i.
module tb_lmem_stream_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] len;
  logic       busy;
  logic       done;
  logic [5:0] raddr;
  logic [7:0] rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] lmem [64];

  int checks = 0;
  int errors = 0;

  lmem_stream_reader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered read port: data for raddr appears the following cycle.
  always @(posedge clk) rdata <= lmem[raddr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] b, input logic [6:0] l);
    start     = s;
    base_addr = b;
    len       = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Called in cycle 1 of an accepted command with out_ready high; returns
  // in the done cycle.
  task automatic checkStream(input int b, input int l);
    for (int c = 1; c <= l + 3; c++) begin
      if (c <= l) checkOutput("raddr", 32'(raddr), 32'((b + c - 1) % 64));
      checkOutput("out_valid", 32'(out_valid), 32'(c >= 3 && c <= l + 2));
      if (c >= 3 && c <= l + 2) checkOutput("out_data", 32'(out_data), 32'((b + c - 3) % 64));
      checkOutput("busy", 32'(busy), 32'(c <= l + 2));
      checkOutput("done", 32'(done), 32'(c == l + 3));
      if (c < l + 3) step();
    end
  endtask

  initial begin
    logic [31:0] pat;
    int          exp_word;
    int          words;
    logic        done_seen;

    for (int i = 0; i < 64; i++) lmem[i] = 8'(i);
    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 6'd0, 7'd0);
    step();
    step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_raddr", 32'(raddr), 32'd0);
    rst = 1'b0;
    step();

    $display("[TB] stream base 4 len 8");
    applyStimulus(1'b1, 6'd4, 7'd8);
    step();
    start = 1'b0;
    checkStream(4, 8);
    step();

    $display("[TB] wrapping stream base 62 len 4");
    applyStimulus(1'b1, 6'd62, 7'd4);
    step();
    start = 1'b0;
    checkStream(62, 4);
    step();

    $display("[TB] zero-length command");
    applyStimulus(1'b1, 6'd9, 7'd0);
    step();
    start = 1'b0;
    checkOutput("len0_done", 32'(done), 32'd1);
    checkOutput("len0_busy", 32'(busy), 32'd0);
    checkOutput("len0_raddr", 32'(raddr), 32'd2);
    checkOutput("len0_out_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("len0_done_clear", 32'(done), 32'd0);
    checkOutput("len0_busy2", 32'(busy), 32'd0);
    checkOutput("len0_raddr2", 32'(raddr), 32'd2);
    checkOutput("len0_out_valid2", 32'(out_valid), 32'd0);

    $display("[TB] backpressure stream base 10 len 16");
    out_ready = 1'b0;
    applyStimulus(1'b1, 6'd10, 7'd16);
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) begin
        checkOutput("bp_stall_raddr", 32'(raddr), 32'd12);
        checkOutput("bp_stall_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_stall_data", 32'(out_data), 32'd10);
        checkOutput("bp_occupancy", 32'(dut.u_fifo.occupancy), 32'd2);
        checkOutput("bp_busy", 32'(busy), 32'd1);
      end
      step();
    end
    pat       = 32'hB6DB_75AD;
    exp_word  = 10;
    words     = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      out_ready = pat[c % 32];
      if (done) begin
        done_seen = 1'b1;
        checkOutput("bp_done_words", 32'(words), 32'd16);
      end else if (out_valid && out_ready) begin
        checkOutput("bp_word", 32'(out_data), 32'(exp_word));
        exp_word++;
        words++;
      end
      step();
    end
    checkOutput("bp_done_seen", 32'(done_seen), 32'd1);
    checkOutput("bp_word_count", 32'(words), 32'd16);
    out_ready = 1'b1;
    step();

    $display("[TB] reset during run");
    applyStimulus(1'b1, 6'd20, 7'd8);
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out_data", 32'(out_data), 32'd0);
    checkOutput("abort_raddr", 32'(raddr), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("abort_discard_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 6'd0, 7'd3);
    step();
    start = 1'b0;
    checkStream(0, 3);
    step();
    checkOutput("abort_tail_valid", 32'(out_valid), 32'd0);

    $display("[TB] back-to-back commands with start held");
    applyStimulus(1'b1, 6'd30, 7'd2);
    step();
    applyStimulus(1'b1, 6'd40, 7'd3);
    checkStream(30, 2);
    step();
    start = 1'b0;
    checkStream(40, 3);
    step();
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
